// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin arbiter with done/drop/hold-limit release
module rr_grant_arbiter #(
    parameter int NREQ     = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_valid,
    output logic            timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]    gnt_id_q, gnt_id_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              timeout_q, timeout_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [7:0]        hold_cnt_q, hold_cnt_d;

    logic              pick_found;
    logic [IDW-1:0]    pick_idx;
    logic [IDW-1:0]    scan_idx;

    // First requester at or after ptr; index arithmetic wraps because NREQ is 2**IDW.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = ptr_q + IDW'(i);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d         = ST_GRANT;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gnt_id_d        = pick_idx;
                    gnt_valid_d     = 1'b1;
                    hold_cnt_d      = '0;
                end
            end
            ST_GRANT: begin
                if (done || !req[gnt_id_q] || (hold_cnt_q == 8'(MAX_HOLD - 1))) begin
                    timeout_d   = !done && req[gnt_id_q];
                    state_d     = ST_IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_id_q + IDW'(1);
                    hold_cnt_d  = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - directed self-checking bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

    localparam int NREQ     = 8;
    localparam int IDW      = 3;
    localparam int MAX_HOLD = 15;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req;
    logic            done;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_valid;
    logic            timeout;

    int errors = 0;
    int checks = 0;

    rr_grant_arbiter #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_id,
                             input logic e_valid, input logic e_to);
        check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        check({tag, ".gnt_id"}, 32'(gnt_id), 32'(e_id));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e_valid));
        check({tag, ".timeout"}, 32'(timeout), 32'(e_to));
    endtask

    // Structural invariants sampled every cycle away from the active edge.
    always @(negedge clk) begin
        checks++;
        assert ($onehot0(gnt) && (gnt_valid === |gnt)
                && (gnt_valid ? (gnt === (8'd1 << gnt_id)) : (gnt_id === 3'd0))) else begin
            errors++;
            $error("FAIL invariant gnt=%0h gnt_id=%0d gnt_valid=%0b", gnt, gnt_id, gnt_valid);
        end
    end

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        tick();
        tick();
        check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single requester, released by done
        req = 8'h04;
        tick();
        check_out("t1_grant", 8'h04, 3'd2, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        check_out("t1_release", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;
        req  = 8'h00;
        tick();
        check_out("t1_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Full rotation from ptr=0 with a bubble between grants
        rst = 1'b1;
        #2;
        rst = 1'b0;
        req = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            check_out($sformatf("t2_grant%0d", k), 8'd1 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
            done = 1'b1;
            tick();
            check_out($sformatf("t2_bubble%0d", k), 8'h00, 3'd0, 1'b0, 1'b0);
            done = 1'b0;
            tick();
        end
        // ptr=1 now and requester 1 has been granted again; release it
        done = 1'b1;
        req  = 8'h20;
        tick();
        done = 1'b0;

        // Wrap past 7: grant 5 sets ptr=6, then req=0x21 picks 0 before 5
        tick();
        check_out("t3_grant5", 8'h20, 3'd5, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h21;
        tick();
        check_out("t3_wrap0", 8'h01, 3'd0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check_out("t3_then5", 8'h20, 3'd5, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;

        // Hold limit: 15 cycles of grant, timeout pulse, bubble, re-grant
        req = 8'h08;
        tick();
        check_out("t4_grant", 8'h08, 3'd3, 1'b1, 1'b0);
        for (int k = 1; k < MAX_HOLD; k++) begin
            tick();
            check_out($sformatf("t4_hold%0d", k), 8'h08, 3'd3, 1'b1, 1'b0);
        end
        tick();
        check_out("t4_timeout", 8'h00, 3'd0, 1'b0, 1'b1);
        tick();
        check_out("t4_regrant", 8'h08, 3'd3, 1'b1, 1'b0);

        // Owner drop releases without timeout; done while idle is ignored
        req = 8'h00;
        tick();
        check_out("t4_drop", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b1;
        tick();
        check_out("idle_done", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;

        // Owner 3 drops with requester 1 pending
        req = 8'h08;
        tick();
        check_out("t5_grant3", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h0A;
        tick();
        check_out("t5_nopreempt", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h02;
        tick();
        check_out("t5_release", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        check_out("t5_grant1", 8'h02, 3'd1, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;

        // Asynchronous reset mid-grant clears outputs and ptr (ptr=2 beforehand)
        req = 8'h04;
        tick();
        check_out("t6_grant2", 8'h04, 3'd2, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_out("t6_async", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'h81;
        #1;
        rst = 1'b0;
        tick();
        check_out("t6_ptr_reset", 8'h01, 3'd0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        check_out("t6_release", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;
        req  = 8'h00;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
